hsid_vctr_streamer: RTL and testbench

//  Transmit side of the element stream consumed by hsid_mse. Holds nothing itself: reads the captured

---
 rtl/hsid_pkg.sv | 38 +++
 rtl/hsid_vctr_streamer.sv | 129 ++++++++++++
 tb/tb_hsid_vctr_streamer.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/hsid_pkg.sv
// Shared HSID types and derived-size helpers for the streamer and the MSE unit.
// Defaults describe the reference configuration: 32-bit words of two 16-bit bands, 8 bands, 4 vectors.
package hsid_pkg;

  localparam int HSID_WORD_WIDTH       = 32;
  localparam int HSID_DATA_WIDTH       = 16;
  localparam int HSID_HSI_BANDS        = 8;
  localparam int HSID_HSI_LIBRARY_SIZE = 4;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } hsid_streamer_state_t;

  function automatic int hsid_clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

  function automatic int hsid_data_per_word(input int word_w, input int data_w);
    return word_w / data_w;
  endfunction

  function automatic int hsid_elements(input int bands, input int word_w, input int data_w);
    return bands / hsid_data_per_word(word_w, data_w);
  endfunction

  function automatic int hsid_lib_addr_w(input int lib_size, input int bands,
                                         input int word_w, input int data_w);
    return hsid_clog2_min1(lib_size * hsid_elements(bands, word_w, data_w));
  endfunction

  localparam int HSID_DATA_PER_WORD = hsid_data_per_word(HSID_WORD_WIDTH, HSID_DATA_WIDTH);
  localparam int HSID_ELEMENTS      = hsid_elements(HSID_HSI_BANDS, HSID_WORD_WIDTH, HSID_DATA_WIDTH);
  localparam int HSID_LIB_ADDR      = hsid_lib_addr_w(HSID_HSI_LIBRARY_SIZE, HSID_HSI_BANDS,
                                                      HSID_WORD_WIDTH, HSID_DATA_WIDTH);

endpackage

// File: rtl/hsid_vctr_streamer.sv
// Streams pixel/library word pairs to the MSE unit; first element 2 cycles after start, one per cycle.
// No backpressure: the consumer must take every element_valid cycle; only clear/rst can stop a run.
module hsid_vctr_streamer
  import hsid_pkg::*;
#(
  parameter int  WORD_WIDTH            = HSID_WORD_WIDTH,
  parameter int  DATA_WIDTH            = HSID_DATA_WIDTH,
  parameter int  HSI_BANDS             = HSID_HSI_BANDS,
  parameter int  HSI_LIBRARY_SIZE      = HSID_HSI_LIBRARY_SIZE,
  localparam int ELEMENTS              = hsid_elements(HSI_BANDS, WORD_WIDTH, DATA_WIDTH),
  localparam int PXL_ADDR              = hsid_clog2_min1(ELEMENTS),
  localparam int LIB_ADDR              = hsid_lib_addr_w(HSI_LIBRARY_SIZE, HSI_BANDS, WORD_WIDTH, DATA_WIDTH),
  localparam int HSI_LIBRARY_SIZE_ADDR = hsid_clog2_min1(HSI_LIBRARY_SIZE)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             clear,
  input  logic [HSI_LIBRARY_SIZE_ADDR:0]   lib_size,
  output logic [PXL_ADDR-1:0]              pxl_addr,
  input  logic [WORD_WIDTH-1:0]            pxl_rdata,
  output logic [LIB_ADDR-1:0]              lib_addr,
  input  logic [WORD_WIDTH-1:0]            lib_rdata,
  output logic                             mem_rd_en,
  output logic                             element_start,
  output logic                             element_last,
  output logic                             element_valid,
  output logic [WORD_WIDTH-1:0]            element_a,
  output logic [WORD_WIDTH-1:0]            element_b,
  output logic [HSI_LIBRARY_SIZE_ADDR-1:0] vctr_ref,
  output logic                             busy,
  output logic                             done
);

  localparam int                        VW       = HSI_LIBRARY_SIZE_ADDR;
  localparam int                        LSW      = VW + 1;
  localparam logic [LSW-1:0]            LIB_MAX  = LSW'(HSI_LIBRARY_SIZE);
  localparam logic [PXL_ADDR-1:0]       WORD_END = PXL_ADDR'(ELEMENTS - 1);

  hsid_streamer_state_t state;
  logic [PXL_ADDR-1:0]  word;
  logic [VW-1:0]        vctr;
  logic [VW-1:0]        n_last;
  logic [LSW-1:0]       lib_eff;
  logic [LSW-1:0]       lib_eff_m1;

  always_comb begin
    lib_eff    = (lib_size > LIB_MAX) ? LIB_MAX : lib_size;
    lib_eff_m1 = lib_eff - 1'b1;
  end

  assign pxl_addr = word;

  // rdata is only meaningful alongside element_valid; gating keeps outputs at 0 in reset/idle.
  assign element_a = element_valid ? pxl_rdata : '0;
  assign element_b = element_valid ? lib_rdata : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      word          <= '0;
      vctr          <= '0;
      n_last        <= '0;
      lib_addr      <= '0;
      mem_rd_en     <= 1'b0;
      element_valid <= 1'b0;
      element_start <= 1'b0;
      element_last  <= 1'b0;
      vctr_ref      <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      // Sideband trails the address by one stage so it lines up with the RAM read data.
      element_valid <= mem_rd_en && !clear;
      element_start <= mem_rd_en && !clear && (word == '0);
      element_last  <= mem_rd_en && !clear && (word == WORD_END);
      vctr_ref      <= (mem_rd_en && !clear) ? vctr : '0;
      done          <= 1'b0;

      if (clear) begin
        state     <= IDLE;
        word      <= '0;
        vctr      <= '0;
        lib_addr  <= '0;
        mem_rd_en <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            busy <= 1'b0;
            if (start && !busy) begin
              if (lib_eff == '0) begin
                done <= 1'b1;
              end else begin
                state     <= STREAM;
                busy      <= 1'b1;
                mem_rd_en <= 1'b1;
                word      <= '0;
                vctr      <= '0;
                lib_addr  <= '0;
                n_last    <= lib_eff_m1[VW-1:0];
              end
            end
          end
          STREAM: begin
            if (word == WORD_END && vctr == n_last) begin
              mem_rd_en <= 1'b0;
              state     <= DRAIN;
            end else begin
              lib_addr <= lib_addr + 1'b1;
              if (word == WORD_END) begin
                word <= '0;
                vctr <= vctr + 1'b1;
              end else begin
                word <= word + 1'b1;
              end
            end
          end
          DRAIN: begin
            done  <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hsid_vctr_streamer.sv
// Directed bench for hsid_vctr_streamer with behavioural 1-cycle pixel and library RAMs.
module tb_hsid_vctr_streamer;
  import hsid_pkg::*;

  localparam int LIB_WORDS = 1 << HSID_LIB_ADDR;
  localparam int RUN_CYC   = 24;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        clear;
  logic [2:0]  lib_size;
  logic [1:0]  pxl_addr;
  logic [31:0] pxl_rdata;
  logic [3:0]  lib_addr;
  logic [31:0] lib_rdata;
  logic        mem_rd_en;
  logic        element_start;
  logic        element_last;
  logic        element_valid;
  logic [31:0] element_a;
  logic [31:0] element_b;
  logic [1:0]  vctr_ref;
  logic        busy;
  logic        done;

  logic [31:0] pxl_mem [HSID_ELEMENTS];
  logic [31:0] lib_mem [LIB_WORDS];

  int checks = 0;
  int errors = 0;

  hsid_vctr_streamer #(
    .WORD_WIDTH      (32),
    .DATA_WIDTH      (16),
    .HSI_BANDS       (8),
    .HSI_LIBRARY_SIZE(4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .clear        (clear),
    .lib_size     (lib_size),
    .pxl_addr     (pxl_addr),
    .pxl_rdata    (pxl_rdata),
    .lib_addr     (lib_addr),
    .lib_rdata    (lib_rdata),
    .mem_rd_en    (mem_rd_en),
    .element_start(element_start),
    .element_last (element_last),
    .element_valid(element_valid),
    .element_a    (element_a),
    .element_b    (element_b),
    .vctr_ref     (vctr_ref),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (mem_rd_en) begin
      pxl_rdata <= pxl_mem[pxl_addr];
      lib_rdata <= lib_mem[lib_addr];
    end
  end

  typedef struct {
    int lib_size;
    int clr_c;       // cycle after start edge in which clear is held, -1 none
    int xstart_c;    // cycle of a stray start pulse, -1 none
    int exp_valid;
    int exp_done_c;  // -1 means done must never pulse
    int exp_max_addr;
    bit exp_busy;
  } vec_t;

  vec_t tab [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_rd_en"}, mem_rd_en, 0);
    check({tag, "_valid"}, element_valid, 0);
    check({tag, "_start"}, element_start, 0);
    check({tag, "_last"}, element_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_lib_addr"}, lib_addr, 0);
    check({tag, "_pxl_addr"}, pxl_addr, 0);
    check({tag, "_vctr_ref"}, vctr_ref, 0);
    check({tag, "_elem_a"}, element_a, 0);
    check({tag, "_elem_b"}, element_b, 0);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int  nval      = 0;
    int  done_c    = -1;
    int  done_cnt  = 0;
    int  max_addr  = 0;
    bit  busy_seen = 0;
    string t;
    t = $sformatf("v%0d", idx);
    @(negedge clk);
    lib_size = 3'(v.lib_size);
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= RUN_CYC; c++) begin
      if (mem_rd_en) begin
        check({t, "_lib_addr"}, lib_addr, c - 1);
        check({t, "_pxl_addr"}, pxl_addr, (c - 1) % 4);
        if (int'(lib_addr) > max_addr) max_addr = int'(lib_addr);
      end
      if (element_valid) begin
        check({t, "_elem_cycle"}, c, 2 + nval);
        if (nval < LIB_WORDS) begin
          check({t, "_elem_a"}, element_a, pxl_mem[nval % 4]);
          check({t, "_elem_b"}, element_b, lib_mem[nval]);
        end
        check({t, "_vctr_ref"}, vctr_ref, nval / 4);
        check({t, "_estart"}, element_start, (nval % 4) == 0);
        check({t, "_elast"}, element_last, (nval % 4) == 3);
        nval++;
      end
      if (busy) busy_seen = 1'b1;
      if (done) begin
        done_cnt++;
        done_c = c;
        if (v.exp_busy) check({t, "_busy_at_done"}, busy, 1);
      end
      clear = (c == v.clr_c);
      start = (c == v.xstart_c);
      @(negedge clk);
    end
    clear = 1'b0;
    start = 1'b0;
    check({t, "_valid_count"}, nval, v.exp_valid);
    check({t, "_done_cycle"}, done_c, v.exp_done_c);
    check({t, "_done_count"}, done_cnt, (v.exp_done_c < 0) ? 0 : 1);
    check({t, "_max_lib_addr"}, max_addr, v.exp_max_addr);
    check({t, "_busy_seen"}, busy_seen, v.exp_busy);
    check({t, "_idle_busy"}, busy, 0);
    check({t, "_idle_valid"}, element_valid, 0);
  endtask

  initial begin
    for (int i = 0; i < HSID_ELEMENTS; i++)
      pxl_mem[i] = {16'(16'hA000 + i * HSID_DATA_PER_WORD), 16'(16'hA001 + i * HSID_DATA_PER_WORD)};
    for (int j = 0; j < LIB_WORDS; j++)
      lib_mem[j] = 32'hB000_0000 + 32'(j * 32'h0101_0011);

    //        lib clr xst valid done maxa busy
    tab[0] = '{3, -1, -1, 12, 14, 11, 1};
    tab[1] = '{0, -1, -1,  0,  1,  0, 0};
    tab[2] = '{7, -1, -1, 16, 18, 15, 1};
    tab[3] = '{4,  6, -1,  5, -1,  5, 1};
    tab[4] = '{3, -1,  5, 12, 14, 11, 1};
    tab[5] = '{1, -1, -1,  4,  6,  3, 1};
    tab[6] = '{4, -1, -1, 16, 18, 15, 1};

    rst      = 1'b1;
    start    = 1'b0;
    clear    = 1'b0;
    lib_size = '0;
    repeat (3) @(negedge clk);
    check_idle_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int k = 0; k < 7; k++) run_vec(k, tab[k]);

    // start and clear together: clear must win, nothing starts
    @(negedge clk);
    lib_size = 3'd2;
    start    = 1'b1;
    clear    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    clear = 1'b0;
    repeat (3) begin
      check("startclr_busy", busy, 0);
      check("startclr_rd_en", mem_rd_en, 0);
      @(negedge clk);
    end

    // asynchronous reset in the middle of a run
    lib_size = 3'd3;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_rst_valid", element_valid, 1);
    #2 rst = 1'b1;
    #1 check_idle_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      check("post_rst_busy", busy, 0);
      check("post_rst_valid", element_valid, 0);
      check("post_rst_rd_en", mem_rd_en, 0);
      @(negedge clk);
    end
    run_vec(7, tab[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
